// File: rtl/seq_core_pipe_ctrl_if.sv
// Fetch/decode/R2 control bundle between the pipeline controller and the sequential core.
// The master modport is the controller side; slave is the pipeline datapath side.
interface seq_core_pipe_ctrl_if #(
    parameter int unsigned A_SIZE = 10,
    parameter int unsigned R_SIZE = 3
);
    logic              id_use_a;
    logic [R_SIZE-1:0] id_src_a;
    logic              id_use_b;
    logic [R_SIZE-1:0] id_src_b;
    logic              r2_load;
    logic [R_SIZE-1:0] r2_dst;
    logic              r2_halt;
    logic              r2_jmp;
    logic              r2_jmpr;
    logic [A_SIZE-1:0] r2_jmp_target;
    logic              mem_busy;
    logic              resume;

    logic              r2_pc_halt;
    logic              r2_pc_load;
    logic              r2_pc_loadr;
    logic [A_SIZE-1:0] r2_pc_target;
    logic              r2_pc_flush;
    logic              bubble;
    logic              r2_kill;

    modport master (
        input  id_use_a, id_src_a, id_use_b, id_src_b,
        input  r2_load, r2_dst, r2_halt, r2_jmp, r2_jmpr, r2_jmp_target,
        input  mem_busy, resume,
        output r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_target,
        output r2_pc_flush, bubble, r2_kill
    );

    modport slave (
        output id_use_a, id_src_a, id_use_b, id_src_b,
        output r2_load, r2_dst, r2_halt, r2_jmp, r2_jmpr, r2_jmp_target,
        output mem_busy, resume,
        input  r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_target,
        input  r2_pc_flush, bubble, r2_kill
    );
endinterface

// File: rtl/seq_core_pipe_ctrl.sv
// Fetch-stage sequencer: resolves halt, taken jumps and load-use hazards, and counts
// stall and flush cycles with saturating counters.
module seq_core_pipe_ctrl #(
    parameter int unsigned A_SIZE = 10,
    parameter int unsigned R_SIZE = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_core_pipe_ctrl_if.master   pipe,
    output logic                   halted,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;

    // ALU results are forwarded, so only a load in R2 feeding the IR instruction stalls.
    assign hazard = pipe.r2_load &
                    ((pipe.id_use_a & (pipe.id_src_a == pipe.r2_dst)) |
                     (pipe.id_use_b & (pipe.id_src_b == pipe.r2_dst)));

    assign pipe.r2_pc_target = pipe.r2_jmp_target;

    always_comb begin
        state_d          = state_q;
        pipe.r2_pc_halt  = 1'b0;
        pipe.r2_pc_load  = 1'b0;
        pipe.r2_pc_loadr = 1'b0;
        pipe.r2_pc_flush = 1'b0;
        pipe.bubble      = 1'b0;
        pipe.r2_kill     = 1'b0;
        halted           = 1'b0;
        // Controls stay quiet while reset is held.
        if (!rst) begin
            case (state_q)
                StRun: begin
                    if (pipe.r2_halt) begin
                        pipe.r2_pc_halt = 1'b1;
                        state_d         = StHalt;
                    end else if (pipe.r2_jmp) begin
                        pipe.r2_pc_load  = 1'b1;
                        pipe.r2_pc_flush = 1'b1;
                        pipe.r2_kill     = 1'b1;
                    end else if (pipe.r2_jmpr) begin
                        pipe.r2_pc_loadr = 1'b1;
                        pipe.r2_pc_flush = 1'b1;
                        pipe.r2_kill     = 1'b1;
                    end else if (hazard) begin
                        pipe.bubble  = 1'b1;
                        pipe.r2_kill = 1'b1;
                        if (pipe.mem_busy) state_d = StStall;
                    end
                end
                StStall: begin
                    if (pipe.mem_busy) begin
                        pipe.bubble  = 1'b1;
                        pipe.r2_kill = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
                StHalt: begin
                    halted = 1'b1;
                    if (pipe.resume) state_d = StRun;
                    else pipe.r2_pc_halt = 1'b1;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pipe.bubble && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (pipe.r2_pc_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_seq_core_pipe_ctrl.sv
// Directed bench for seq_core_pipe_ctrl: default-width instance plus a 4-bit-counter
// instance used for saturation and mid-stall reset.
module tb_seq_core_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst4;
    logic        halted, halted4;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_core_pipe_ctrl_if #(.A_SIZE(10), .R_SIZE(3)) pi ();
    seq_core_pipe_ctrl_if #(.A_SIZE(10), .R_SIZE(3)) pi4 ();

    seq_core_pipe_ctrl #(.A_SIZE(10), .R_SIZE(3), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe      (pi.master),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    seq_core_pipe_ctrl #(.A_SIZE(10), .R_SIZE(3), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst4),
        .pipe      (pi4.master),
        .halted    (halted4),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pi.id_use_a = 0; pi.id_src_a = 0; pi.id_use_b = 0; pi.id_src_b = 0;
        pi.r2_load = 0; pi.r2_dst = 0; pi.r2_halt = 0; pi.r2_jmp = 0; pi.r2_jmpr = 0;
        pi.r2_jmp_target = 0; pi.mem_busy = 0; pi.resume = 0;
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [5:0] exp);
        chk(tag, {pi.r2_pc_halt, pi.r2_pc_load, pi.r2_pc_loadr, pi.r2_pc_flush,
                  pi.bubble, pi.r2_kill}, {26'd0, exp});
    endtask

    initial begin
        idle();
        pi4.id_use_a = 0; pi4.id_src_a = 0; pi4.id_use_b = 0; pi4.id_src_b = 0;
        pi4.r2_load = 0; pi4.r2_dst = 0; pi4.r2_halt = 0; pi4.r2_jmp = 0; pi4.r2_jmpr = 0;
        pi4.r2_jmp_target = 0; pi4.mem_busy = 0; pi4.resume = 0;
        rst = 1; rst4 = 1;
        pi.r2_halt = 1;
        #2;
        chk_ctrl("rst_ctrl", 6'b000000);
        chk("rst_halted", halted, 0);
        chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
        #10 rst = 0; rst4 = 0;
        #1;
        chk_ctrl("post_rst_halt", 6'b100000);
        chk("post_rst_halted", halted, 0);
        tick(); #1;
        chk("halt_halted", halted, 1);
        chk_ctrl("halt_ctrl", 6'b100000);
        pi.r2_halt = 0; pi.resume = 1; #1;
        chk_ctrl("resume_ctrl", 6'b000000);
        chk("resume_halted", halted, 1);
        tick(); pi.resume = 0; #1;
        chk("run_halted", halted, 0);
        chk_ctrl("run_idle", 6'b000000);

        // Relative jump
        pi.r2_jmpr = 1; pi.r2_jmp_target = 10'h3FE; #1;
        chk_ctrl("jmpr_ctrl", 6'b001101);
        chk("jmpr_target", pi.r2_pc_target, 10'h3FE);
        chk("jmpr_fcnt_before", flush_cnt, 0);
        tick(); idle(); #1;
        chk_ctrl("jmpr_after", 6'b000000);
        chk("jmpr_fcnt", flush_cnt, 1);

        // Load-use hazard with memory busy for three cycles
        pi.r2_load = 1; pi.r2_dst = 3; pi.id_use_b = 1; pi.id_src_b = 3; pi.mem_busy = 1; #1;
        chk_ctrl("haz_c1", 6'b000011);
        tick(); #1;
        chk_ctrl("haz_c2", 6'b000011);
        tick(); #1;
        chk_ctrl("haz_c3", 6'b000011);
        chk("haz_scnt2", stall_cnt, 2);
        tick(); pi.mem_busy = 0; #1;
        chk_ctrl("haz_c4", 6'b000000);
        chk("haz_scnt3", stall_cnt, 3);
        tick(); idle(); pi.r2_jmp = 1; pi.r2_jmp_target = 10'h055; #1;
        chk_ctrl("haz_back_run", 6'b010101);
        chk("jmp_target", pi.r2_pc_target, 10'h055);
        tick(); idle(); #1;
        chk("jmp_fcnt", flush_cnt, 2);
        chk("jmp_scnt", stall_cnt, 3);

        // Single-cycle bubble when load data is already available
        pi.r2_load = 1; pi.r2_dst = 5; pi.id_use_a = 1; pi.id_src_a = 5; #1;
        chk_ctrl("haz1_c1", 6'b000011);
        tick(); idle(); #1;
        chk_ctrl("haz1_c2", 6'b000000);
        chk("haz1_scnt", stall_cnt, 4);
        pi.r2_load = 1; pi.r2_dst = 5; pi.id_use_a = 0; pi.id_src_a = 5; #1;
        chk_ctrl("no_use_no_haz", 6'b000000);
        tick(); idle();

        // Halt beats jump; jumps ignored while halted
        pi.r2_halt = 1; pi.r2_jmp = 1; #1;
        chk_ctrl("halt_jmp", 6'b100000);
        tick(); pi.r2_halt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_ctrl("halt_hold", 6'b100000);
            chk("halt_hold_halted", halted, 1);
            tick();
        end
        chk("halt_fcnt", flush_cnt, 2);
        pi.resume = 1; #1;
        chk_ctrl("halt_resume", 6'b000000);
        tick(); pi.resume = 0; pi.r2_jmpr = 1; #1;
        chk_ctrl("jmp_beats_jmpr", 6'b010101);
        tick(); idle(); #1;
        chk("final_fcnt", flush_cnt, 3);

        // Saturation on the 4-bit instance
        pi4.r2_load = 1; pi4.r2_dst = 2; pi4.id_use_a = 1; pi4.id_src_a = 2; pi4.mem_busy = 1;
        for (int i = 0; i < 14; i++) tick();
        #1;
        chk("sat_scnt14", stall_cnt4, 14);
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("sat_scnt15", stall_cnt4, 15);
        chk("sat_bubble", pi4.bubble, 1);
        rst4 = 1; #1;
        chk("rst_mid_stall_cnt", stall_cnt4, 0);
        chk("rst_mid_stall_bubble", pi4.bubble, 0);
        tick(); rst4 = 0; pi4.mem_busy = 0; #1;
        chk("rst_back_run_bubble", pi4.bubble, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
